// File: rtl/dk_pkg.sv
// Shared Donkey Kong playfield types: motion states, keycodes and the ladder table.
package dk_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        CLIMB  = 2'd1,
        JUMP   = 2'd2
    } state_t;

    localparam logic [7:0] KEY_UP        = 8'h1A;
    localparam logic [7:0] KEY_UP_ALT    = 8'h52;
    localparam logic [7:0] KEY_DOWN      = 8'h16;
    localparam logic [7:0] KEY_DOWN_ALT  = 8'h51;
    localparam logic [7:0] KEY_LEFT      = 8'h04;
    localparam logic [7:0] KEY_LEFT_ALT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT     = 8'h07;
    localparam logic [7:0] KEY_RIGHT_ALT = 8'h4F;
    localparam logic [7:0] KEY_JUMP      = 8'h2C;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] w;
        logic [2:0] lo;
    } ladder_t;

    localparam int NUM_LADDERS = 8;

    // Ordered by priority: the first entry that matches wins.
    localparam ladder_t LADDERS [NUM_LADDERS] = '{
        '{10'd300, 10'd15, 3'd0},
        '{10'd535, 10'd15, 3'd0},
        '{10'd100, 10'd15, 3'd1},
        '{10'd250, 10'd15, 3'd2},
        '{10'd500, 10'd15, 3'd2},
        '{10'd120, 10'd15, 3'd3},
        '{10'd320, 10'd15, 3'd3},
        '{10'd515, 10'd15, 3'd4}
    };

    function automatic logic key_up(input logic [7:0] k);
        return (k == KEY_UP) || (k == KEY_UP_ALT);
    endfunction

    function automatic logic key_down(input logic [7:0] k);
        return (k == KEY_DOWN) || (k == KEY_DOWN_ALT);
    endfunction

    function automatic logic key_left(input logic [7:0] k);
        return (k == KEY_LEFT) || (k == KEY_LEFT_ALT);
    endfunction

    function automatic logic key_right(input logic [7:0] k);
        return (k == KEY_RIGHT) || (k == KEY_RIGHT_ALT);
    endfunction

endpackage

// File: rtl/ladder_match.sv
// Combinational ladder lookup: is PlayerX inside a ladder that leaves floor_idx
// upward (direction=1) or arrives at floor_idx from below (direction=0)?
module ladder_match
    import dk_pkg::*;
(
    input  logic [9:0] PlayerX,
    input  logic [2:0] floor_idx,
    input  logic       direction,
    output logic       hit,
    output logic [2:0] lo
);

    always_comb begin
        hit = 1'b0;
        lo  = 3'd0;
        // Scan from the back so the lowest matching index is the one left standing.
        for (int i = NUM_LADDERS - 1; i >= 0; i--) begin
            if (({1'b0, PlayerX} >= {1'b0, LADDERS[i].x}) &&
                ({1'b0, PlayerX} <  ({1'b0, LADDERS[i].x} + {1'b0, LADDERS[i].w})) &&
                (direction ? (LADDERS[i].lo == floor_idx)
                           : (({1'b0, LADDERS[i].lo} + 4'd1) == {1'b0, floor_idx}))) begin
                hit = 1'b1;
                lo  = LADDERS[i].lo;
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Per-frame player motion: walk on floors, climb table-driven ladders, gravity jump.
// Optional PLAYER_AIR_CONTROL_EN lets the held left/right key steer vx while airborne.
module player_ctrl
    import dk_pkg::*;
#(
    parameter int NUM_FLOORS  = 6,
    parameter int FLOOR_BASE  = 414,
    parameter int FLOOR_PITCH = 60,
    parameter int SPAWN_X     = 50,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int SIZE        = 16,
    parameter int WALK_STEP   = 2,
    parameter int CLIMB_STEP  = 1,
    parameter int JUMP_V      = 6,
    parameter int GRAV_DIV    = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [9:0] PlayerS,
    output logic [2:0] floor_idx,
    output logic       airborne,
    output logic       on_ladder,
    output logic       facing_left
);

    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic signed [10:0] XLO     = 11'(X_MIN);
    localparam logic signed [10:0] XHI     = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] CLIMB_S = 11'(CLIMB_STEP);
    localparam logic signed [5:0]  WALK6   = 6'(WALK_STEP);
    localparam logic signed [5:0]  VY_MAX  = 6'(JUMP_V);

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        floor_q, floor_d, lad_q, lad_d;
    logic signed [5:0] vy_q, vy_d, vx_q, vx_d, vx_t;
    logic [GW-1:0]     grav_q, grav_d;
    logic [7:0]        prev_q;
    logic              face_q, face_d;
    logic              lad_hit, lad_ok, jump_edge;
    logic [2:0]        lad_lo;
    logic signed [10:0] x_ext, y_ext, y_t;
    logic [9:0]        fy_cur, fy_lo, fy_hi;

    function automatic logic [9:0] floor_y(input logic [2:0] k);
        return 10'(FLOOR_BASE - int'(k) * FLOOR_PITCH);
    endfunction

    function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
        if (v < XLO) return XLO[9:0];
        if (v > XHI) return XHI[9:0];
        return v[9:0];
    endfunction

    function automatic logic signed [10:0] sx(input logic signed [5:0] v);
        return {{5{v[5]}}, v};
    endfunction

    function automatic logic signed [5:0] dir_v(input logic [7:0] k);
        if (key_left(k))  return -WALK6;
        if (key_right(k)) return WALK6;
        return 6'sd0;
    endfunction

    ladder_match u_ladder (
        .PlayerX   (x_q),
        .floor_idx (floor_q),
        .direction (key_up(keycode)),
        .hit       (lad_hit),
        .lo        (lad_lo)
    );

    assign lad_ok    = lad_hit && ((int'(lad_lo) + 1) < NUM_FLOORS);
    assign jump_edge = (keycode == KEY_JUMP) && (prev_q != KEY_JUMP);
    assign x_ext     = $signed({1'b0, x_q});
    assign y_ext     = $signed({1'b0, y_q});
    assign fy_cur    = floor_y(floor_q);
    assign fy_lo     = floor_y(lad_q);
    assign fy_hi     = floor_y(lad_q + 3'd1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        floor_d = floor_q;
        vy_d    = vy_q;
        vx_d    = vx_q;
        grav_d  = grav_q;
        lad_d   = lad_q;
        face_d  = face_q;
        vx_t    = vx_q;
        y_t     = y_ext;
        case (state_q)
            GROUND: begin
                y_d = fy_cur;
                if (key_left(keycode)) begin
                    x_d    = clamp_x(x_ext - sx(WALK6));
                    face_d = 1'b1;
                end else if (key_right(keycode)) begin
                    x_d    = clamp_x(x_ext + sx(WALK6));
                    face_d = 1'b0;
                end else if (jump_edge) begin
                    // Keycode carries one key, so the run-up direction is last frame's key.
                    state_d = JUMP;
                    vy_d    = -VY_MAX;
                    vx_d    = dir_v(prev_q);
                    grav_d  = '0;
                end else if ((key_up(keycode) || key_down(keycode)) && lad_ok) begin
                    state_d = CLIMB;
                    lad_d   = lad_lo;
                end
            end
            CLIMB: begin
                if (key_up(keycode))        y_t = y_ext - CLIMB_S;
                else if (key_down(keycode)) y_t = y_ext + CLIMB_S;
                y_d = y_t[9:0];
                if (y_t <= $signed({1'b0, fy_hi})) begin
                    y_d     = fy_hi;
                    floor_d = lad_q + 3'd1;
                    state_d = GROUND;
                end else if (y_t >= $signed({1'b0, fy_lo})) begin
                    y_d     = fy_lo;
                    floor_d = lad_q;
                    state_d = GROUND;
                end
            end
            JUMP: begin
`ifdef PLAYER_AIR_CONTROL_EN
                vx_t = dir_v(keycode);
                if (key_left(keycode))  face_d = 1'b1;
                if (key_right(keycode)) face_d = 1'b0;
`endif
                vx_d = vx_t;
                x_d  = clamp_x(x_ext + sx(vx_t));
                y_t  = y_ext + sx(vy_q);
                y_d  = y_t[9:0];
                if (grav_q == GW'(GRAV_DIV - 1)) begin
                    grav_d = '0;
                    if (vy_q < VY_MAX) vy_d = vy_q + 6'sd1;
                end else begin
                    grav_d = grav_q + GW'(1);
                end
                if ((vy_q > 6'sd0) && (y_t >= $signed({1'b0, fy_cur}))) begin
                    y_d     = fy_cur;
                    state_d = GROUND;
                    vy_d    = 6'sd0;
                    vx_d    = 6'sd0;
                    grav_d  = '0;
                end
            end
            default: state_d = GROUND;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= GROUND;
            x_q     <= 10'(SPAWN_X);
            y_q     <= 10'(FLOOR_BASE);
            floor_q <= 3'd0;
            vy_q    <= 6'sd0;
            vx_q    <= 6'sd0;
            grav_q  <= '0;
            lad_q   <= 3'd0;
            prev_q  <= 8'h00;
            face_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            floor_q <= floor_d;
            vy_q    <= vy_d;
            vx_q    <= vx_d;
            grav_q  <= grav_d;
            lad_q   <= lad_d;
            prev_q  <= keycode;
            face_q  <= face_d;
        end
    end

    assign PlayerX     = x_q;
    assign PlayerY     = y_q;
    assign PlayerS     = 10'(SIZE);
    assign floor_idx   = floor_q;
    assign airborne    = (state_q == JUMP);
    assign on_ladder   = (state_q == CLIMB);
    assign facing_left = face_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: frame-level reference model feeds an expected queue.
module tb_player_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic [9:0] PlayerX, PlayerY, PlayerS;
    logic [2:0] floor_idx;
    logic       airborne, on_ladder, facing_left;

    player_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .PlayerX     (PlayerX),
        .PlayerY     (PlayerY),
        .PlayerS     (PlayerS),
        .floor_idx   (floor_idx),
        .airborne    (airborne),
        .on_ladder   (on_ladder),
        .facing_left (facing_left)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int x, y, fl;
        bit air, lad, face;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   frame_no = 0;

    // Reference model state: mode 0 walk, 1 ladder, 2 airborne; mt = frames since takeoff.
    int mx, my, mfl, mmode, mvx, mt, mlad, mface, mprev;
    int LX [8] = '{300, 535, 100, 250, 500, 120, 320, 515};
    int LL [8] = '{0, 0, 1, 2, 2, 3, 3, 4};

    function automatic int fy(input int k);
        return 414 - 60 * k;
    endfunction

    function automatic int clampx(input int v);
        if (v < 0)   return 0;
        if (v > 623) return 623;
        return v;
    endfunction

    function automatic int dirv(input int k);
        if (k == 'h04 || k == 'h50) return -2;
        if (k == 'h07 || k == 'h4F) return 2;
        return 0;
    endfunction

    task automatic model_step(input int k, input bit r);
        int d, ny, vy;
        bit up, dn;
        up = (k == 'h1A || k == 'h52);
        dn = (k == 'h16 || k == 'h51);
        d  = dirv(k);
        if (r) begin
            mx = 50; my = 414; mfl = 0; mmode = 0; mvx = 0; mt = 0; mlad = 0; mface = 0;
        end else if (mmode == 0) begin
            my = fy(mfl);
            if (d != 0) begin
                mx = clampx(mx + d);
                mface = (d < 0);
            end else if (k == 'h2C && mprev != 'h2C) begin
                mmode = 2; mt = 0; mvx = dirv(mprev);
            end else if (up || dn) begin
                for (int i = 0; i < 8; i++) begin
                    if (mx >= LX[i] && mx < LX[i] + 15 &&
                        (up ? (LL[i] == mfl) : (LL[i] + 1 == mfl))) begin
                        mmode = 1; mlad = LL[i];
                        break;
                    end
                end
            end
        end else if (mmode == 1) begin
            ny = my + (up ? -1 : (dn ? 1 : 0));
            if (ny <= fy(mlad + 1)) begin
                my = fy(mlad + 1); mfl = mlad + 1; mmode = 0;
            end else if (ny >= fy(mlad)) begin
                my = fy(mlad); mfl = mlad; mmode = 0;
            end else begin
                my = ny;
            end
        end else begin
            vy = -6 + mt / 4;
            if (vy > 6) vy = 6;
`ifdef PLAYER_AIR_CONTROL_EN
            mvx = d;
            if (d != 0) mface = (d < 0);
`endif
            mx = clampx(mx + mvx);
            if (vy > 0 && my + vy >= fy(mfl)) begin
                my = fy(mfl); mmode = 0;
            end else begin
                my = my + vy; mt++;
            end
        end
        mprev = r ? 0 : k;
    endtask

    task automatic frame(input logic [7:0] k, input bit r);
        exp_t e;
        @(negedge frame_clk);
        keycode = k;
        Reset   = r;
        model_step(int'(k), r);
        e.x = mx; e.y = my; e.fl = mfl;
        e.air = (mmode == 2); e.lad = (mmode == 1); e.face = (mface != 0);
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every frame the DUT presents new outputs one edge after the key.
    always @(posedge frame_clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            frame_no++;
            n_tests++;
            if (int'(PlayerX) != e.x || int'(PlayerY) != e.y || int'(floor_idx) != e.fl ||
                airborne !== e.air || on_ladder !== e.lad || facing_left !== e.face ||
                PlayerS !== 10'd16) begin
                n_fail++;
                $display("FAIL frame %0d: got x=%0d y=%0d fl=%0d air=%0b lad=%0b face=%0b s=%0d, expected x=%0d y=%0d fl=%0d air=%0b lad=%0b face=%0b s=16",
                         frame_no, PlayerX, PlayerY, floor_idx, airborne, on_ladder, facing_left, PlayerS,
                         e.x, e.y, e.fl, e.air, e.lad, e.face);
            end
        end
    end

    initial begin
        logic [7:0] keys [12];
        int apex, miny, x1, x2, vy;
        bit seen_air;
        keys = '{8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h2C, 8'h2C, 8'h33};

        frame(8'h00, 1'b1);
        frame(8'h00, 1'b1);
        settle();
        chk("reset_x", int'(PlayerX), 50);
        chk("reset_y", int'(PlayerY), 414);
        chk("reset_floor", int'(floor_idx), 0);

        // Walk right 10 frames.
        for (int i = 0; i < 10; i++) frame(8'h07, 1'b0);
        settle();
        chk("walk_x", int'(PlayerX), 70);
        chk("walk_y", int'(PlayerY), 414);
        chk("walk_face", int'(facing_left), 0);

        // Walk to X=304 (inside ladder at 300) and climb to floor 1.
        for (int i = 0; i < 117; i++) frame(8'h07, 1'b0);
        for (int i = 0; i < 61; i++) begin
            frame(8'h1A, 1'b0);
            if (i == 30) begin
                settle();
                chk("climb_on_ladder", int'(on_ladder), 1);
            end
        end
        settle();
        chk("climb_y", int'(PlayerY), 354);
        chk("climb_floor", int'(floor_idx), 1);
        chk("climb_done", int'(on_ladder), 0);

        // Back down, then a straight-up jump from floor 0.
        for (int i = 0; i < 61; i++) frame(8'h16, 1'b0);
        frame(8'h00, 1'b0);
        frame(8'h00, 1'b0);
        apex = 414;
        for (int t = 0; ; t++) begin
            vy = -6 + t / 4;
            if (vy >= 0) break;
            apex += vy;
        end
        frame(8'h2C, 1'b0);
        miny = 1023;
        seen_air = 0;
        for (int i = 0; i < 60; i++) begin
            frame(8'h00, 1'b0);
            settle();
            if (airborne) seen_air = 1;
            if (int'(PlayerY) < miny) miny = int'(PlayerY);
        end
        chk("jump_airborne_seen", int'(seen_air), 1);
        chk("jump_apex", miny, apex);
        chk("jump_land_y", int'(PlayerY), 414);
        chk("jump_landed", int'(airborne), 0);

        // Left into X_MIN must stick at 0.
        for (int i = 0; i < 170; i++) frame(8'h04, 1'b0);
        settle();
        chk("xmin_clamp", int'(PlayerX), 0);
        chk("xmin_face", int'(facing_left), 1);

        // Reset in the middle of a climb.
        for (int i = 0; i < 152; i++) frame(8'h07, 1'b0);
        for (int i = 0; i < 35; i++) frame(8'h1A, 1'b0);
        settle();
        chk("midclimb_y", int'(PlayerY), 380);
        frame(8'h1A, 1'b1);
        settle();
        chk("rst_climb_x", int'(PlayerX), 50);
        chk("rst_climb_y", int'(PlayerY), 414);
        chk("rst_climb_lad", int'(on_ladder), 0);

        // Running jump to the right, then steer left mid-air.
        for (int i = 0; i < 3; i++) frame(8'h07, 1'b0);
        for (int i = 0; i < 5; i++) frame(8'h2C, 1'b0);
        settle();
        x1 = int'(PlayerX);
        for (int i = 0; i < 8; i++) frame(8'h04, 1'b0);
        settle();
        x2 = int'(PlayerX);
`ifdef PLAYER_AIR_CONTROL_EN
        chk("air_steer", x2, x1 - 16);
`else
        chk("air_steer", x2, x1 + 16);
`endif
        for (int i = 0; i < 50; i++) frame(8'h00, 1'b0);

        // Jump key held through reset fires once after release.
        frame(8'h2C, 1'b1);
        frame(8'h2C, 1'b0);
        settle();
        chk("jump_through_reset", int'(airborne), 1);
        for (int i = 0; i < 60; i++) frame(8'h2C, 1'b0);
        settle();
        chk("held_jump_no_retrigger", int'(airborne), 0);

        // Randomized key sequences.
        for (int s = 0; s < 700; s++) begin
            logic [7:0] k;
            int hold;
            k = keys[$urandom_range(0, 11)];
            hold = $urandom_range(1, 30);
            if ($urandom_range(0, 149) == 0) frame(k, 1'b1);
            for (int h = 0; h < hold; h++) frame(k, 1'b0);
        end

        repeat (3) settle();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected frames left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
